// File: rtl/fetch_queue_pkg.sv
// Shared frontend definitions for the fetch queue: slot/lane widths and the
// stored entry layout (PC plus raw instruction word).
package fetch_queue_pkg;

  localparam int unsigned FETCH_WIDTH = 2;   // instruction slots per fetch packet
  localparam int unsigned DEC_WIDTH   = 2;   // instructions presented to decode per cycle
  localparam int unsigned INST_W      = 32;  // instruction word width
  localparam int unsigned XLEN        = 32;  // PC width

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Storage array for the fetch queue: DEPTH x fq_entry_t registers.
//   clk_i      clock
//   wr_en_i    per-port write enable (FETCH_WIDTH ports)
//   wr_addr_i  per-port write address
//   wr_data_i  per-port write data
//   rd_addr_i  per-lane read address (DEC_WIDTH combinational ports)
//   rd_data_o  per-lane read data
// Storage is deliberately not reset; validity is tracked by the pointer logic.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned PtrW  = 4
) (
  input  logic                                  clk_i,
  input  logic      [FETCH_WIDTH-1:0]           wr_en_i,
  input  logic      [FETCH_WIDTH-1:0][PtrW-1:0] wr_addr_i,
  input  fq_entry_t [FETCH_WIDTH-1:0]           wr_data_i,
  input  logic      [DEC_WIDTH-1:0][PtrW-1:0]   rd_addr_i,
  output fq_entry_t [DEC_WIDTH-1:0]             rd_data_o
);

  fq_entry_t mem_q [Depth];

  // Write addresses within one packet are always distinct (consecutive slots).
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en_i[i]) begin
        mem_q[wr_addr_i[i]] <= wr_data_i[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEC_WIDTH; i++) begin
      rd_data_o[i] = mem_q[rd_addr_i[i]];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch stage 3 and decode.
//   clock, reset               single clock, synchronous active-high reset
//   io_i_flush                 stage-3 flush; clears the queue, blocks enqueue and dequeue
//   io_i_fetch_pack_*          fetch packet: valid, slot-0 PC, slot instructions, slot mask
//   io_o_full                  fewer than FETCH_WIDTH free entries (from registered count)
//   io_i_dec_ready             decode accepts the whole presented group
//   io_o_dec_valid/pc/inst     up to DEC_WIDTH in-order lanes (thermometer valid)
//   io_o_count                 occupied entries
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_i_flush,
  input  logic                          io_i_fetch_pack_valid,
  input  logic [XLEN-1:0]               io_i_fetch_pack_pc,
  input  logic [INST_W*FETCH_WIDTH-1:0] io_i_fetch_pack_insts,
  input  logic [FETCH_WIDTH-1:0]        io_i_fetch_pack_valids,
  output logic                          io_o_full,
  input  logic                          io_i_dec_ready,
  output logic [DEC_WIDTH-1:0]          io_o_dec_valid,
  output logic [XLEN*DEC_WIDTH-1:0]     io_o_dec_pc,
  output logic [INST_W*DEC_WIDTH-1:0]   io_o_dec_inst,
  output logic [$clog2(DEPTH):0]        io_o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] n_enq, n_deq;
  logic            full, enq_fire, deq_fire;
  logic [DEC_WIDTH-1:0] dec_valid;

  logic      [FETCH_WIDTH-1:0]           wr_en;
  logic      [FETCH_WIDTH-1:0][PtrW-1:0] wr_addr;
  fq_entry_t [FETCH_WIDTH-1:0]           wr_data;
  logic      [DEC_WIDTH-1:0][PtrW-1:0]   rd_addr;
  fq_entry_t [DEC_WIDTH-1:0]             rd_data;

  // Full looks only at the registered count so the upstream stall has no
  // combinational path from decode ready.
  assign full     = (CntW'(DEPTH) - count_q) < CntW'(FETCH_WIDTH);
  assign enq_fire = io_i_fetch_pack_valid & ~full & ~io_i_flush;
  assign deq_fire = io_i_dec_ready & ~io_i_flush;

  // Compaction: each valid slot lands at tail + (number of valid slots before it).
  // The stored PC is that of the original slot, so holes do not shift PCs.
  always_comb begin
    n_enq   = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_addr[i]      = tail_q + n_enq[PtrW-1:0];
      wr_data[i].pc   = io_i_fetch_pack_pc + XLEN'(4 * i);
      wr_data[i].inst = io_i_fetch_pack_insts[INST_W*i +: INST_W];
      if (io_i_fetch_pack_valids[i]) begin
        wr_en[i] = enq_fire;
        n_enq    = n_enq + CntW'(1);
      end
    end
    if (!enq_fire) begin
      n_enq = '0;
    end
  end

  // Decode lanes read straight from registered state; no enqueue bypass.
  always_comb begin
    dec_valid     = '0;
    n_deq         = '0;
    rd_addr       = '0;
    io_o_dec_pc   = '0;
    io_o_dec_inst = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      rd_addr[i]                         = head_q + PtrW'(i);
      dec_valid[i]                       = ~io_i_flush & (count_q > CntW'(i));
      io_o_dec_pc[XLEN*i +: XLEN]        = rd_data[i].pc;
      io_o_dec_inst[INST_W*i +: INST_W]  = rd_data[i].inst;
      if (deq_fire && dec_valid[i]) begin
        n_deq = n_deq + CntW'(1);
      end
    end
  end

  always_comb begin
    head_d  = head_q + n_deq[PtrW-1:0];
    tail_d  = tail_q + n_enq[PtrW-1:0];
    count_d = count_q + n_enq - n_deq;
    if (io_i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fetch_queue_ram #(
    .Depth (DEPTH),
    .PtrW  (PtrW)
  ) u_ram (
    .clk_i     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign io_o_full      = full;
  assign io_o_dec_valid = dec_valid;
  assign io_o_count     = count_q;

endmodule
